// File: rtl/instr_fetch.sv
// Program counter and instruction-fetch stage feeding the opcode decoder.
// Holds the PC, addresses a combinational instruction memory and runs start/halt control.
module instr_fetch #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [PC_W-1:0]  START_ADDR,
  output logic [PC_W-1:0]  IMEM_ADDR,
  input  logic [8:0]       IMEM_DATA,
  output logic [8:0]       INSTR,
  output logic [4:0]       OPCODE,
  input  logic             BRANCH,
  input  logic             BRANCH_COND,
  input  logic             HALT,
  output logic             RUNNING,
  output logic             DONE,
  output logic [CNT_W-1:0] CYCLE_CNT
);

  localparam int unsigned OFF_W = 4;
  localparam logic [8:0]  IDLE_INSTR = 9'h0F0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state;
  logic [PC_W-1:0]  pc;
  logic [CNT_W-1:0] cycle_cnt;
  logic             running;
  logic             done;
  logic [PC_W-1:0]  branch_off;

  // Outside RUN the decoder sees a harmless halt instruction.
  assign INSTR      = (state == RUN) ? IMEM_DATA : IDLE_INSTR;
  assign OPCODE     = INSTR[8:4];
  assign IMEM_ADDR  = pc;
  assign RUNNING    = running;
  assign DONE       = done;
  assign CYCLE_CNT  = cycle_cnt;
  assign branch_off = {{(PC_W-OFF_W){INSTR[OFF_W-1]}}, INSTR[OFF_W-1:0]};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      pc        <= '0;
      cycle_cnt <= '0;
      running   <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (START) begin
            state     <= RUN;
            pc        <= START_ADDR;
            cycle_cnt <= '0;
            running   <= 1'b1;
            done      <= 1'b0;
          end
        end
        RUN: begin
          if (cycle_cnt != '1) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
          end
          // Halt outranks a taken branch; PC arithmetic wraps naturally.
          if (HALT) begin
            state   <= HALTED;
            running <= 1'b0;
            done    <= 1'b1;
          end else if (BRANCH && BRANCH_COND) begin
            pc <= pc + branch_off;
          end else begin
            pc <= pc + PC_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a wide-counter instance and a 4-bit-counter instance
// share stimulus and instruction memory; a tiny decoder model closes the loop.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic        start;
  logic [9:0]  start_addr;
  logic        branch_cond;
  logic        halt_force;
  logic        branch_force;

  logic [9:0]  imem_addr, imem_addr_s;
  logic [8:0]  imem_data, imem_data_s;
  logic [8:0]  instr, instr_s;
  logic [4:0]  opcode, opcode_s;
  logic        branch, branch_s, halt, halt_s;
  logic        running, running_s, done, done_s;
  logic [15:0] cycle_cnt;
  logic [3:0]  cycle_cnt_s;

  logic [8:0]  mem [0:1023];

  int checks;
  int failures;

  // Decoder model: opcode 15 halts, opcode 16 branches; forces add extra requests.
  assign imem_data   = mem[imem_addr];
  assign imem_data_s = mem[imem_addr_s];
  assign halt        = (opcode == 5'd15) | halt_force;
  assign branch      = (opcode == 5'd16) | branch_force;
  assign halt_s      = (opcode_s == 5'd15) | halt_force;
  assign branch_s    = (opcode_s == 5'd16) | branch_force;

  instr_fetch #(.PC_W(10), .CNT_W(16)) u_dut (
    .CLK(clk), .RESET(reset), .START(start), .START_ADDR(start_addr),
    .IMEM_ADDR(imem_addr), .IMEM_DATA(imem_data), .INSTR(instr), .OPCODE(opcode),
    .BRANCH(branch), .BRANCH_COND(branch_cond), .HALT(halt),
    .RUNNING(running), .DONE(done), .CYCLE_CNT(cycle_cnt)
  );

  instr_fetch #(.PC_W(10), .CNT_W(4)) u_sat (
    .CLK(clk), .RESET(reset), .START(start), .START_ADDR(start_addr),
    .IMEM_ADDR(imem_addr_s), .IMEM_DATA(imem_data_s), .INSTR(instr_s), .OPCODE(opcode_s),
    .BRANCH(branch_s), .BRANCH_COND(branch_cond), .HALT(halt_s),
    .RUNNING(running_s), .DONE(done_s), .CYCLE_CNT(cycle_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (imem_addr !== 10'd0 || running !== 1'b0 || done !== 1'b0 || cycle_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_state pc=%0d run=%0b done=%0b cnt=%0d exp pc=0 run=0 done=0 cnt=0",
               imem_addr, running, done, cycle_cnt);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (imem_addr !== 10'd0 || running !== 1'b0 || done !== 1'b0 ||
          opcode !== 5'd15 || instr !== 9'h0F0 || cycle_cnt !== 16'd0 || cycle_cnt_s !== 4'd0) begin
        failures++;
        $display("FAIL idle_hold[%0d] pc=%0d run=%0b done=%0b op=%0d cnt=%0d exp pc=0 run=0 done=0 op=15 cnt=0",
                 i, imem_addr, running, done, opcode, cycle_cnt);
      end
    end
  endtask

  task automatic test_straight_line();
    mem[10] = 9'h010; mem[11] = 9'h023; mem[12] = 9'h045; mem[13] = 9'h0E7; mem[14] = 9'h0F0;
    start_addr = 10'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (imem_addr !== 10'(10 + i) || instr !== mem[10 + i] || running !== 1'b1) begin
        failures++;
        $display("FAIL straight_pc[%0d] pc=%0d instr=%h run=%0b exp pc=%0d instr=%h run=1",
                 i, imem_addr, instr, running, 10 + i, mem[10 + i]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || running !== 1'b0 || imem_addr !== 10'd14 || cycle_cnt !== 16'd5) begin
      failures++;
      $display("FAIL straight_halt done=%0b run=%0b pc=%0d cnt=%0d exp done=1 run=0 pc=14 cnt=5",
               done, running, imem_addr, cycle_cnt);
    end
    tick();
    checks++;
    if (imem_addr !== 10'd14 || cycle_cnt !== 16'd5 || opcode !== 5'd15) begin
      failures++;
      $display("FAIL halted_hold pc=%0d cnt=%0d op=%0d exp pc=14 cnt=5 op=15", imem_addr, cycle_cnt, opcode);
    end
  endtask

  task automatic test_branch();
    mem[20] = 9'h10D;
    start_addr = 10'd20;
    branch_cond = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (imem_addr !== 10'd20 || opcode !== 5'd16) begin
      failures++;
      $display("FAIL branch_setup pc=%0d op=%0d exp pc=20 op=16", imem_addr, opcode);
    end
    tick();
    checks++;
    if (imem_addr !== 10'd17) begin
      failures++;
      $display("FAIL branch_taken pc=%0d exp 17", imem_addr);
    end
    halt_force = 1'b1;
    tick();
    halt_force = 1'b0;
    branch_cond = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (imem_addr !== 10'd21) begin
      failures++;
      $display("FAIL branch_not_taken pc=%0d exp 21", imem_addr);
    end
    halt_force = 1'b1;
    tick();
    halt_force = 1'b0;
    mem[0] = 9'h10F;
    start_addr = 10'd0;
    branch_cond = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (imem_addr !== 10'd1023) begin
      failures++;
      $display("FAIL branch_wrap_down pc=%0d exp 1023", imem_addr);
    end
    tick();
    checks++;
    if (imem_addr !== 10'd0) begin
      failures++;
      $display("FAIL pc_wrap_up pc=%0d exp 0", imem_addr);
    end
    halt_force = 1'b1;
    tick();
    halt_force = 1'b0;
    checks++;
    if (imem_addr !== 10'd0 || done !== 1'b1 || cycle_cnt !== 16'd3) begin
      failures++;
      $display("FAIL wrap_halt pc=%0d done=%0b cnt=%0d exp pc=0 done=1 cnt=3", imem_addr, done, cycle_cnt);
    end
  endtask

  task automatic test_priority();
    mem[50] = 9'h101;
    start_addr = 10'd50;
    branch_cond = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    halt_force = 1'b1;
    tick();
    halt_force = 1'b0;
    checks++;
    if (done !== 1'b1 || running !== 1'b0 || imem_addr !== 10'd50 || cycle_cnt !== 16'd1) begin
      failures++;
      $display("FAIL halt_over_branch done=%0b run=%0b pc=%0d cnt=%0d exp done=1 run=0 pc=50 cnt=1",
               done, running, imem_addr, cycle_cnt);
    end
    branch_cond = 1'b0;
  endtask

  task automatic test_restart();
    start_addr = 10'd100;
    start = 1'b1;
    tick();
    start_addr = 10'd300;
    tick();
    tick();
    checks++;
    if (imem_addr !== 10'd102) begin
      failures++;
      $display("FAIL start_ignored_in_run pc=%0d exp 102", imem_addr);
    end
    start = 1'b0;
    halt_force = 1'b1;
    tick();
    halt_force = 1'b0;
    checks++;
    if (done !== 1'b1 || imem_addr !== 10'd102 || cycle_cnt !== 16'd3) begin
      failures++;
      $display("FAIL run_halt done=%0b pc=%0d cnt=%0d exp done=1 pc=102 cnt=3", done, imem_addr, cycle_cnt);
    end
    start_addr = 10'd5;
    start = 1'b1;
    tick();
    checks++;
    if (imem_addr !== 10'd5 || cycle_cnt !== 16'd0 || done !== 1'b0 || running !== 1'b1) begin
      failures++;
      $display("FAIL restart pc=%0d cnt=%0d done=%0b run=%0b exp pc=5 cnt=0 done=0 run=1",
               imem_addr, cycle_cnt, done, running);
    end
    halt_force = 1'b1;
    tick();
    halt_force = 1'b0;
    checks++;
    if (done !== 1'b1 || running !== 1'b0 || cycle_cnt !== 16'd1) begin
      failures++;
      $display("FAIL held_start_halt done=%0b run=%0b cnt=%0d exp done=1 run=0 cnt=1", done, running, cycle_cnt);
    end
    tick();
    checks++;
    if (running !== 1'b1 || done !== 1'b0 || imem_addr !== 10'd5 || cycle_cnt !== 16'd0) begin
      failures++;
      $display("FAIL held_start_rerun run=%0b done=%0b pc=%0d cnt=%0d exp run=1 done=0 pc=5 cnt=0",
               running, done, imem_addr, cycle_cnt);
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    halt_force = 1'b1;
    tick();
    halt_force = 1'b0;
    start_addr = 10'd33;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (imem_addr !== 10'd33 || running !== 1'b1) begin
      failures++;
      $display("FAIL mid_run_setup pc=%0d run=%0b exp pc=33 run=1", imem_addr, running);
    end
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    checks++;
    if (imem_addr !== 10'd0 || running !== 1'b0 || done !== 1'b0 || cycle_cnt !== 16'd0 || opcode !== 5'd15) begin
      failures++;
      $display("FAIL reset_mid_run pc=%0d run=%0b done=%0b cnt=%0d op=%0d exp pc=0 run=0 done=0 cnt=0 op=15",
               imem_addr, running, done, cycle_cnt, opcode);
    end
  endtask

  task automatic test_saturation();
    mem[200] = 9'h100;
    start_addr = 10'd200;
    branch_cond = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (cycle_cnt_s !== 4'd15 || cycle_cnt !== 16'd20 || imem_addr_s !== 10'd200) begin
      failures++;
      $display("FAIL saturate cnt4=%0d cnt16=%0d pc=%0d exp cnt4=15 cnt16=20 pc=200",
               cycle_cnt_s, cycle_cnt, imem_addr_s);
    end
    halt_force = 1'b1;
    tick();
    halt_force = 1'b0;
    checks++;
    if (cycle_cnt_s !== 4'd15 || cycle_cnt !== 16'd21 || done_s !== 1'b1 || running_s !== 1'b0) begin
      failures++;
      $display("FAIL saturate_halt cnt4=%0d cnt16=%0d done=%0b run=%0b exp cnt4=15 cnt16=21 done=1 run=0",
               cycle_cnt_s, cycle_cnt, done_s, running_s);
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    start        = 1'b0;
    start_addr   = 10'd0;
    branch_cond  = 1'b0;
    halt_force   = 1'b0;
    branch_force = 1'b0;
    for (int a = 0; a < 1024; a++) mem[a] = 9'h010;

    test_reset();
    test_straight_line();
    test_branch();
    test_priority();
    test_restart();
    test_reset_mid_run();
    test_saturation();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
